// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_seq
//  Description : Iterative signed multiply/divide unit with its own sequencer.
//                One shared shift datapath runs unsigned shift-add
//                multiplication or restoring division on operand magnitudes.
//                A final sign step then produces the signed HI:LO result.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             mult_ctrl,
    input  logic             div_ctrl,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             mult_end,
    output logic             div_end,
    output logic             div_zero,
    output logic             busy
);

    // Accumulator width: a carry/guard bit above the HI:LO pair.
    localparam int          ACC_W    = 2 * WIDTH + 1;
    localparam int          CNT_W    = 6;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ITER    = 3'd1,
        S_SIGN    = 3'd2,
        S_DONE    = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_op_div;
    logic               r_sign_a;
    logic               r_sign_b;
    logic [WIDTH-1:0]   r_mag_a;
    logic [WIDTH-1:0]   r_mag_b;
    logic [ACC_W-1:0]   r_acc;

    logic [WIDTH-1:0]   w_mag_rs;
    logic [WIDTH-1:0]   w_mag_rt;
    logic [WIDTH:0]     w_mul_sum;
    logic [ACC_W-1:0]   w_mul_next;
    logic [WIDTH:0]     w_div_rem;
    logic [WIDTH+1:0]   w_div_trial;
    logic [ACC_W-1:0]   w_div_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_signed;
    logic [WIDTH-1:0]   w_quot_signed;
    logic [WIDTH-1:0]   w_rem_signed;

    // Operand magnitudes; the most negative value maps to its unsigned
    // magnitude, which the unsigned magnitude registers hold exactly.
    always_comb begin
        w_mag_rs = rs[WIDTH-1] ? (~rs + 1'b1) : rs;
        w_mag_rt = rt[WIDTH-1] ? (~rt + 1'b1) : rt;
    end

    // One shift-add multiply step: conditional add into the upper half,
    // then shift the whole accumulator right by one.
    always_comb begin
        w_mul_sum  = r_acc[ACC_W-1:WIDTH] + (r_acc[0] ? {1'b0, r_mag_a} : '0);
        w_mul_next = {1'b0, w_mul_sum, r_acc[WIDTH-1:1]};
    end

    // One restoring-division step: shift remainder:quotient left, trial
    // subtract the divisor with an extra sign bit, keep or restore.
    always_comb begin
        w_div_rem   = r_acc[ACC_W-2:WIDTH-1];
        w_div_trial = {1'b0, w_div_rem} - {2'b00, r_mag_b};
        if (!w_div_trial[WIDTH+1]) begin
            w_div_next = {w_div_trial[WIDTH:0], r_acc[WIDTH-2:0], 1'b1};
        end else begin
            w_div_next = {w_div_rem, r_acc[WIDTH-2:0], 1'b0};
        end
    end

    // Sign correction applied to the unsigned iteration results.
    always_comb begin
        w_prod        = r_acc[2*WIDTH-1:0];
        w_prod_signed = (r_sign_a ^ r_sign_b) ? (~w_prod + 1'b1) : w_prod;
        w_quot_signed = (r_sign_a ^ r_sign_b) ? (~r_acc[WIDTH-1:0] + 1'b1)
                                              : r_acc[WIDTH-1:0];
        w_rem_signed  = r_sign_a ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1)
                                 : r_acc[2*WIDTH-1:WIDTH];
    end

    // Sequencer, datapath registers and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op_div <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_mag_a  <= '0;
            r_mag_b  <= '0;
            r_acc    <= '0;
            hi       <= '0;
            lo       <= '0;
            mult_end <= 1'b0;
            div_end  <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
        end else begin
            mult_end <= 1'b0;
            div_end  <= 1'b0;
            div_zero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (mult_ctrl) begin
                        r_op_div <= 1'b0;
                        r_sign_a <= rs[WIDTH-1];
                        r_sign_b <= rt[WIDTH-1];
                        r_mag_a  <= w_mag_rs;
                        r_mag_b  <= w_mag_rt;
                        // Multiplier magnitude sits in the low half.
                        r_acc    <= {{(WIDTH+1){1'b0}}, w_mag_rt};
                        r_cnt    <= '0;
                        r_state  <= S_ITER;
                        busy     <= 1'b1;
                    end else if (div_ctrl) begin
                        if (rt == '0) begin
                            // Divide by zero: skip straight to DONE, HI/LO untouched.
                            div_end  <= 1'b1;
                            div_zero <= 1'b1;
                            r_state  <= S_DONE;
                            busy     <= 1'b1;
                        end else begin
                            r_op_div <= 1'b1;
                            r_sign_a <= rs[WIDTH-1];
                            r_sign_b <= rt[WIDTH-1];
                            r_mag_a  <= w_mag_rs;
                            r_mag_b  <= w_mag_rt;
                            // Dividend magnitude enters as the initial quotient bits.
                            r_acc    <= {{(WIDTH+1){1'b0}}, w_mag_rs};
                            r_cnt    <= '0;
                            r_state  <= S_ITER;
                            busy     <= 1'b1;
                        end
                    end
                end
                S_ITER: begin
                    r_acc <= r_op_div ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == C_CNT_LAST) begin
                        r_state <= S_SIGN;
                    end
                end
                S_SIGN: begin
                    if (r_op_div) begin
                        hi      <= w_rem_signed;
                        lo      <= w_quot_signed;
                        div_end <= 1'b1;
                    end else begin
                        hi       <= w_prod_signed[2*WIDTH-1:WIDTH];
                        lo       <= w_prod_signed[WIDTH-1:0];
                        mult_end <= 1'b1;
                    end
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_RELEASE;
                end
                S_RELEASE: begin
                    // Wait for the requester to drop so a held level cannot relaunch.
                    if (!mult_ctrl && !div_ctrl) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_seq
//  Description : Self-checking bench for muldiv_seq. Expected results come
//                from a signed 64-bit arithmetic model and are queued when a
//                request is driven, then popped when the DUT signals done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        mult_ctrl;
    logic        div_ctrl;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        mult_end;
    logic        div_end;
    logic        div_zero;
    logic        busy;

    muldiv_seq #(.WIDTH(32)) dut (
        .clock    (clock),
        .reset    (reset),
        .mult_ctrl(mult_ctrl),
        .div_ctrl (div_ctrl),
        .rs       (rs),
        .rt       (rt),
        .hi       (hi),
        .lo       (lo),
        .mult_end (mult_end),
        .div_end  (div_end),
        .div_zero (div_zero),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        zero;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] m_hi     = '0;
    logic [31:0] m_lo     = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: signed 64-bit arithmetic; divide by zero keeps previous HI/LO.
    function automatic exp_t model(input bit is_mult, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa;
        longint sb_;
        longint p;
        longint q;
        longint r;
        sa     = longint'($signed(a));
        sb_    = longint'($signed(b));
        e.zero = 1'b0;
        e.cyc  = 34;
        if (is_mult) begin
            p    = sa * sb_;
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (b == 32'd0) begin
            e.hi   = m_hi;
            e.lo   = m_lo;
            e.zero = 1'b1;
            e.cyc  = 1;
        end else begin
            q    = sa / sb_;
            r    = sa % sb_;
            e.hi = r[31:0];
            e.lo = q[31:0];
        end
        return e;
    endfunction

    task automatic run_op(input string tag, input bit do_mult, input bit do_div,
                          input logic [31:0] a, input logic [31:0] b, input int hold);
        exp_t e;
        exp_t x;
        int   mcount = 0;
        int   dcount = 0;
        int   got    = 0;
        @(negedge clock);
        rs        = a;
        rt        = b;
        mult_ctrl = do_mult;
        div_ctrl  = do_div;
        e = model(do_mult, a, b);
        sb.push_back(e);
        m_hi = e.hi;
        m_lo = e.lo;
        for (int c = 1; c <= hold; c++) begin
            @(posedge clock);
            #1;
            // Operands must have been captured already; disturb them.
            if (c == 2) begin
                rs = $urandom;
                rt = $urandom;
            end
            if (mult_end) mcount++;
            if (div_end) dcount++;
            if ((mult_end || div_end) && got == 0 && sb.size() > 0) begin
                x   = sb.pop_front();
                got = 1;
                check({tag, ":end_cycle"}, 64'(c), 64'(x.cyc));
                check({tag, ":hi"}, {32'd0, hi}, {32'd0, x.hi});
                check({tag, ":lo"}, {32'd0, lo}, {32'd0, x.lo});
                check({tag, ":div_zero"}, {63'd0, div_zero}, {63'd0, x.zero});
            end
        end
        check({tag, ":end_seen"}, 64'(got), 64'd1);
        if (got == 0 && sb.size() > 0) x = sb.pop_front();
        check({tag, ":mult_pulses"}, 64'(mcount), do_mult ? 64'd1 : 64'd0);
        check({tag, ":div_pulses"}, 64'(dcount), do_mult ? 64'd0 : 64'd1);
        check({tag, ":busy_release"}, {63'd0, busy}, 64'd1);
        @(negedge clock);
        mult_ctrl = 1'b0;
        div_ctrl  = 1'b0;
        @(posedge clock);
        #1;
        check({tag, ":busy_idle"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        mult_ctrl = 1'b0;
        div_ctrl  = 1'b0;
        rs        = '0;
        rt        = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst:hi", {32'd0, hi}, 64'd0);
        check("rst:lo", {32'd0, lo}, 64'd0);
        check("rst:busy", {63'd0, busy}, 64'd0);
        check("rst:mult_end", {63'd0, mult_end}, 64'd0);
        check("rst:div_end", {63'd0, div_end}, 64'd0);
        check("rst:div_zero", {63'd0, div_zero}, 64'd0);
        reset = 1'b0;

        run_op("t1_mul", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 40);
        check("t1_const_hi", {32'd0, hi}, 64'hFFFF_FFFF);
        check("t1_const_lo", {32'd0, lo}, 64'hFFFF_FFEB);
        run_op("t2_div", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 40);
        check("t2_const_hi", {32'd0, hi}, 64'hFFFF_FFFF);
        check("t2_const_lo", {32'd0, lo}, 64'hFFFF_FFFD);
        run_op("t3_pre", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 40);
        run_op("t3_dz", 1'b0, 1'b1, 32'd5, 32'd0, 10);
        check("t3_const_hi", {32'd0, hi}, 64'hFFFF_FFFF);
        check("t3_const_lo", {32'd0, lo}, 64'hFFFF_FFEB);
        run_op("t4_mul", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 40);
        run_op("t4_div", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 40);
        check("t4_const_hi", {32'd0, hi}, 64'd0);
        check("t4_const_lo", {32'd0, lo}, 64'h8000_0000);
        run_op("t5_both", 1'b1, 1'b1, 32'd6, 32'd3, 40);
        run_op("d_pos", 1'b0, 1'b1, 32'd100, 32'd7, 40);
        run_op("d_negdiv", 1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, 40);
        for (int i = 0; i < 4; i++) begin
            run_op((i % 2 == 0) ? "rnd_mul" : "rnd_div", (i % 2 == 0), (i % 2 != 0),
                   $urandom, $urandom, 40);
        end

        // Reset in cycle 10 of a multiply aborts it.
        @(negedge clock);
        rs        = 32'd12345;
        rt        = 32'd678;
        mult_ctrl = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("t6_rst:hi", {32'd0, hi}, 64'd0);
        check("t6_rst:lo", {32'd0, lo}, 64'd0);
        check("t6_rst:busy", {63'd0, busy}, 64'd0);
        check("t6_rst:ends", {62'd0, mult_end, div_end}, 64'd0);
        reset     = 1'b0;
        mult_ctrl = 1'b0;
        m_hi      = '0;
        m_lo      = '0;
        run_op("t6_mul", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 40);
        check("t6_const_hi", {32'd0, hi}, 64'd0);
        check("t6_const_lo", {32'd0, lo}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative signed multiply/divide unit with its own sequencer, serving the multicycle control FSM's MULT and DIV states. The control FSM holds `mult_ctrl` or `div_ctrl` high and waits for `mult_end` or `div_end`. This block then produces the 64-bit HI:LO result that the HI and LO registers load under `hi_ctrl`/`lo_ctrl`. One shared 32-iteration shift datapath serves both operations.

## Interface

- `WIDTH`, default 32: operand width. HI and LO are each `WIDTH` bits. The iteration count equals `WIDTH`.
- `clock` input 1: single clock. All state updates on the rising edge.
- `reset` input 1: synchronous, active-high. Sampled on the rising edge of `clock`.
- `mult_ctrl` input 1: multiply request, level. Held high by the control FSM until `mult_end`.
- `div_ctrl` input 1: divide request, level. Held high by the control FSM until `div_end`.
- `rs` input `WIDTH`: operand A (multiplicand or dividend). Two's complement.
- `rt` input `WIDTH`: operand B (multiplier or divisor). Two's complement.
- `hi` output `WIDTH`: HI result, registered. Upper product bits, or the remainder.
- `lo` output `WIDTH`: LO result, registered. Lower product bits, or the quotient.
- `mult_end` output 1: one-cycle pulse; multiply result is valid.
- `div_end` output 1: one-cycle pulse; divide finished, normally or by zero.
- `div_zero` output 1: one-cycle pulse, coincident with `div_end`, when the divisor is 0.
- `busy` output 1: high in every state except IDLE.

## Operation

- **States:** IDLE, ITER, SIGN, DONE, RELEASE. A 6-bit iteration counter `cnt` runs alongside.
- **IDLE**
  - Sampling `mult_ctrl`=1 latches |rs|, |rt|, the operand signs and op=MULT, clears the accumulator and `cnt`, and moves to ITER.
  - Sampling `div_ctrl`=1 (and `mult_ctrl`=0) with `rt`≠0 does the same with op=DIV.
  - Sampling `div_ctrl`=1 with `rt`=0 goes straight to DONE with the zero flag set.
  - `mult_ctrl` has priority when both requests are high.
  - Operands are captured only on this edge. Later changes to `rs`/`rt` have no effect.
- **ITER, MULT:** unsigned shift-add. If the accumulator LSB is 1, add the magnitude into the upper half. Then shift the 2·WIDTH+1 register right by one.
- **ITER, DIV:** restoring division. Shift remainder:quotient left by one, then trial-subtract the divisor. If the result is non-negative, keep it and set the quotient LSB to 1; otherwise restore.
- **ITER exit:** `cnt` increments each edge. Leave to SIGN after `WIDTH` iterations (`cnt`=WIDTH−1 on the last one).
- **SIGN, MULT:** if the operand signs differ, negate the 64-bit product in two's complement. Write it to `hi`/`lo`.
- **SIGN, DIV:**
  - Negate the quotient if the signs differ; negate the remainder if the dividend is negative.
  - Write remainder→`hi` and quotient→`lo`.
  - Quotient truncates toward zero. The remainder takes the dividend's sign.
- **SIGN exit:** go to DONE.
- **DONE**
  - Assert `mult_end` (MULT) or `div_end` (DIV) for exactly this cycle.
  - On divide-by-zero, `div_end` and `div_zero` are both high, and `hi`/`lo` keep their previous values.
  - Go to RELEASE.
- **RELEASE:** stay until `mult_ctrl`=0 and `div_ctrl`=0 are sampled, then go to IDLE. This prevents a still-held request from relaunching the operation.
- **Overflow case:** −2^31 ÷ −1 gives `lo`=0x80000000 and `hi`=0 (wraps). No exception is raised.
- **Magnitude rule:** |−2^31| is taken as unsigned 0x80000000. Magnitude registers are unsigned `WIDTH` bits, so this value is correct.

## Timing

- **Reset values:** `hi`=0, `lo`=0, `mult_end`=0, `div_end`=0, `div_zero`=0, `busy`=0, state=IDLE, `cnt`=0.
- **Reset mid-operation:** aborts the operation and restores all the reset values on that edge.
- **Reset priority:** `reset` takes priority over any request on the same edge.
- **Cycle numbering:** the request is first sampled at the end of cycle 0.
  - Cycles 1..WIDTH: ITER.
  - Cycle WIDTH+1: SIGN.
  - Cycle WIDTH+2: DONE. `*_end` is high and `hi`/`lo` are already valid. For WIDTH=32 this is cycle 34.
- **Divide-by-zero latency:** DONE in cycle 1, so `div_end`=`div_zero`=1 in cycle 1.
- **Output stability:** `hi`/`lo` change only on the SIGN→DONE edge and hold until the next operation's SIGN.
- **Outputs are registered:** no combinational path from inputs to outputs.
- **Requests outside IDLE:** ignored while `busy`=1.

## Test plan

1. `mult_ctrl`=1, rs=7, rt=−3 → `mult_end` pulses in cycle 34 only; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
2. `div_ctrl`=1, rs=−7, rt=2 → `div_end` in cycle 34; lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1), `div_zero`=0.
3. With hi/lo preloaded from test 1: `div_ctrl`=1, rt=0 → `div_end`=`div_zero`=1 in cycle 1 only; hi/lo unchanged; block waits in RELEASE until `div_ctrl` drops.
4. rs=0x80000000, rt=0xFFFFFFFF, both multiply and divide:
   - Multiply → hi=0, lo=0x80000000.
   - Divide → lo=0x80000000, hi=0.
5. `mult_ctrl` and `div_ctrl` rise together (rs=6, rt=3) → multiply runs; hi=0, lo=18; `div_end` never pulses. Holding `mult_ctrl` high for 5 cycles after `mult_end` → no second `mult_end`.
6. `reset` asserted in cycle 10 of a multiply → next cycle all outputs are 0 and `busy`=0. A fresh multiply (rs=0xFFFFFFFF, rt=0xFFFFFFFF) then gives hi=0, lo=1.
